// File: rtl/pattern_source_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_source_pkg
// Description : Shared types and constants for the pattern_source test-data
//               generator: pattern mode encoding, FSM state encoding and the
//               default LFSR feedback taps (x^4 + x^3 + 1 for 4-bit words).
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_source_pkg;

    // Pattern selection, encoded to match the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_WALK = 2'd3
    } mode_e;

    // Burst sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Fibonacci taps on bits 3 and 2: maximal-length sequence for 4-bit words.
    localparam logic [3:0] C_DEFAULT_LFSR_TAPS = 4'b1100;

endpackage : pattern_source_pkg
`default_nettype wire

// File: rtl/pattern_step.sv
`default_nettype none
// ============================================================================
// Module      : pattern_step
// Description : Combinational next-value function for the pattern generator.
//               Given the current word, it returns the next word of the
//               selected pattern.
//   mode  : pattern select (UP, DOWN, LFSR, WALK)
//   cur   : current word
//   limit : wrap value for UP/DOWN
//   taps  : LFSR feedback mask, bit i set means cur[i] feeds the XOR
//   nxt   : next word
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_step
    import pattern_source_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  mode_e              mode,
    input  logic [DATA_W-1:0]  cur,
    input  logic [DATA_W-1:0]  limit,
    input  logic [DATA_W-1:0]  taps,
    output logic [DATA_W-1:0]  nxt
);

    always_comb begin
        nxt = cur;
        case (mode)
            // Counters wrap at the programmed limit rather than at 2^DATA_W.
            MODE_UP:   nxt = (cur == limit) ? '0 : cur + 1'b1;
            MODE_DOWN: nxt = (cur == '0) ? limit : cur - 1'b1;
            MODE_LFSR: nxt = {cur[DATA_W-2:0], ^(cur & taps)};
            MODE_WALK: nxt = {cur[DATA_W-2:0], cur[DATA_W-1]};
            default:   nxt = cur;
        endcase
    end

endmodule : pattern_step
`default_nettype wire

// File: rtl/pattern_source.sv
`default_nettype none
// ============================================================================
// Module      : pattern_source
// Description : Burst test-data source. Produces DATA_W-bit words in one of
//               four patterns over a valid/ready handshake, with programmable
//               seed, wrap limit and burst length (0 = continuous).
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, abort          : begin a burst (IDLE only) / terminate a burst
//   mode, seed, limit,
//   burst_len             : burst configuration, sampled on an accepted start
//   out_data, out_valid,
//   out_ready             : word stream handshake
//   busy, done            : burst running / one-cycle normal completion pulse
//   word_count            : transfers in the current or last burst
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_source
    import pattern_source_pkg::*;
#(
    parameter int                 DATA_W    = 4,
    parameter int                 LEN_W     = 8,
    parameter logic [DATA_W-1:0]  LFSR_TAPS = C_DEFAULT_LFSR_TAPS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [DATA_W-1:0]  seed,
    input  logic [DATA_W-1:0]  limit,
    input  logic [LEN_W-1:0]   burst_len,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   word_count
);

    state_e              r_state;
    state_e              w_state_next;
    mode_e               r_mode;
    mode_e               w_mode_in;
    logic [DATA_W-1:0]   r_limit;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_step;
    logic [DATA_W-1:0]   w_seed_eff;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_count;
    logic [LEN_W-1:0]    w_count_inc;
    logic                r_run;
    logic                r_done;
    logic                w_start;
    logic                w_xfer;
    logic                w_last;

    assign w_mode_in   = mode_e'(mode);
    assign w_start     = (r_state == ST_IDLE) && start;
    assign w_xfer      = (r_state == ST_RUN) && out_ready;
    assign w_count_inc = r_count + 1'b1;
    // A zero length means "run until abort", so it never matches here.
    assign w_last      = (r_len != '0) && (w_count_inc == r_len);

    // Counters start inside their wrap range; shift patterns must not start
    // at zero, where the LFSR would lock up and the walking bit would vanish.
    always_comb begin
        w_seed_eff = seed;
        case (w_mode_in)
            MODE_UP, MODE_DOWN: w_seed_eff = (seed <= limit) ? seed : '0;
            default:            w_seed_eff = (seed != '0) ? seed : DATA_W'(1);
        endcase
    end

    pattern_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .mode  (r_mode),
        .cur   (r_data),
        .limit (r_limit),
        .taps  (LFSR_TAPS),
        .nxt   (w_data_step)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN: begin
                // Abort takes priority over a simultaneous final transfer.
                if (abort)                 w_state_next = ST_IDLE;
                else if (w_xfer && w_last) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they track the
    // state register exactly without decode glitches on the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_run  <= (w_state_next == ST_RUN);
            r_done <= (w_state_next == ST_DONE);
        end
    end

    // ---------------- Configuration, data and counter ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode  <= MODE_UP;
            r_limit <= '0;
            r_len   <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else if (w_start) begin
            r_mode  <= w_mode_in;
            r_limit <= limit;
            r_len   <= burst_len;
            r_data  <= w_seed_eff;
            r_count <= '0;
        end else if (w_xfer) begin
            // Also taken on an abort cycle: that transfer still counts.
            r_data  <= w_data_step;
            r_count <= w_count_inc;
        end
    end

    assign out_data   = r_data;
    assign out_valid  = r_run;
    assign busy       = r_run;
    assign done       = r_done;
    assign word_count = r_count;

endmodule : pattern_source
`default_nettype wire

// File: tb/tb_pattern_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_source
// Description : Self-checking bench for pattern_source (DATA_W=4, LEN_W=8).
//               Cycle vectors from a table, plus hand-written sequences for
//               the LFSR period, stalled WALK, and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_source;

    localparam logic [1:0] M_UP   = 2'd0;
    localparam logic [1:0] M_DOWN = 2'd1;
    localparam logic [1:0] M_LFSR = 2'd2;
    localparam logic [1:0] M_WALK = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] seed = 4'd0;
    logic [3:0] limit = 4'd0;
    logic [7:0] burst_len = 8'd0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] word_count;

    int n_applied = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pattern_source dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .seed       (seed),
        .limit      (limit),
        .burst_len  (burst_len),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    typedef struct {
        logic       start;
        logic       abort;
        logic [1:0] mode;
        logic [3:0] seed;
        logic [3:0] limit;
        logic [7:0] len;
        logic       ready;
        logic       e_valid;
        logic [3:0] e_data;
        logic       e_busy;
        logic       e_done;
        logic [7:0] e_count;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(input int st, input int ab, input logic [1:0] md,
                                input int sd, input int lm, input int ln, input int rd,
                                input int ev, input int ed, input int eb, input int edn,
                                input int ec);
        vec_t v;
        v.start   = st[0];
        v.abort   = ab[0];
        v.mode    = md;
        v.seed    = sd[3:0];
        v.limit   = lm[3:0];
        v.len     = ln[7:0];
        v.ready   = rd[0];
        v.e_valid = ev[0];
        v.e_data  = ed[3:0];
        v.e_busy  = eb[0];
        v.e_done  = edn[0];
        v.e_count = ec[7:0];
        return v;
    endfunction

    // Packed view of all observable outputs: {valid, data, busy, done, count}.
    function automatic logic [14:0] pk(input logic v, input logic [3:0] d, input logic b,
                                       input logic dn, input logic [7:0] c);
        return {v, d, b, dn, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return pk(out_valid, out_data, busy, done, word_count);
    endfunction

    int lfsr_exp [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    int walk_exp [4]  = '{1, 2, 4, 8};

    initial begin
        logic [15:0] seen;
        int          idx;
        logic        rdy;

        // ------------------------------------------------------------------
        // Table: {start, abort, mode, seed, limit, len, ready} ->
        //        {valid, data, busy, done, count} one cycle later.
        // ------------------------------------------------------------------
        // UP 3..5 wrap, six words; start during RUN ignored
        tbl[0]  = mk(1, 0, M_UP,   3,  5, 6, 1,   1, 3, 1, 0, 0);
        tbl[1]  = mk(0, 0, M_UP,   0,  0, 0, 1,   1, 4, 1, 0, 1);
        tbl[2]  = mk(0, 0, M_UP,   0,  0, 0, 1,   1, 5, 1, 0, 2);
        tbl[3]  = mk(1, 0, M_DOWN, 9, 15, 2, 1,   1, 0, 1, 0, 3);
        tbl[4]  = mk(0, 0, M_UP,   0,  0, 0, 1,   1, 1, 1, 0, 4);
        tbl[5]  = mk(0, 0, M_UP,   0,  0, 0, 1,   1, 2, 1, 0, 5);
        tbl[6]  = mk(0, 0, M_UP,   0,  0, 0, 1,   0, 3, 0, 1, 6);
        // start/abort in DONE ignored, start+abort in first IDLE: start wins
        tbl[7]  = mk(1, 1, M_UP,   9,  9, 1, 1,   0, 3, 0, 0, 6);
        tbl[8]  = mk(1, 1, M_UP,   1,  7, 2, 1,   1, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, M_UP,   0,  0, 0, 1,   1, 2, 1, 0, 1);
        tbl[10] = mk(0, 0, M_UP,   0,  0, 0, 0,   1, 2, 1, 0, 1);
        tbl[11] = mk(0, 0, M_UP,   0,  0, 0, 1,   0, 3, 0, 1, 2);
        tbl[12] = mk(0, 0, M_UP,   0,  0, 0, 0,   0, 3, 0, 0, 2);
        // UP with seed above limit starts at 0
        tbl[13] = mk(1, 0, M_UP,   7,  5, 1, 0,   1, 0, 1, 0, 0);
        tbl[14] = mk(0, 0, M_UP,   0,  0, 0, 1,   0, 1, 0, 1, 1);
        tbl[15] = mk(0, 0, M_UP,   0,  0, 0, 0,   0, 1, 0, 0, 1);
        // DOWN 2,1,0,9,... continuous, abort on the 4th transfer
        tbl[16] = mk(1, 0, M_DOWN, 2,  9, 0, 1,   1, 2, 1, 0, 0);
        tbl[17] = mk(0, 0, M_UP,   0,  0, 0, 1,   1, 1, 1, 0, 1);
        tbl[18] = mk(0, 0, M_UP,   0,  0, 0, 1,   1, 0, 1, 0, 2);
        tbl[19] = mk(0, 0, M_UP,   0,  0, 0, 1,   1, 9, 1, 0, 3);
        tbl[20] = mk(0, 1, M_UP,   0,  0, 0, 1,   0, 8, 0, 0, 4);
        tbl[21] = mk(0, 0, M_UP,   0,  0, 0, 0,   0, 8, 0, 0, 4);
        // DOWN with seed above limit starts at 0, then wraps to limit
        tbl[22] = mk(1, 0, M_DOWN, 12, 9, 1, 1,   1, 0, 1, 0, 0);
        tbl[23] = mk(0, 0, M_UP,   0,  0, 0, 1,   0, 9, 0, 1, 1);
        tbl[24] = mk(0, 1, M_UP,   0,  0, 0, 0,   0, 9, 0, 0, 1);

        // ---------------- Reset state ----------------
        #2;
        chk("reset_outputs", 32'(outs()), 32'(pk(0, 0, 0, 0, 0)));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 32'(outs()), 32'(pk(0, 0, 0, 0, 0)));

        // ---------------- Table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            start     = tbl[i].start;
            abort     = tbl[i].abort;
            mode      = tbl[i].mode;
            seed      = tbl[i].seed;
            limit     = tbl[i].limit;
            burst_len = tbl[i].len;
            out_ready = tbl[i].ready;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'(pk(tbl[i].e_valid, tbl[i].e_data, tbl[i].e_busy,
                       tbl[i].e_done, tbl[i].e_count)));
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;

        // ---------------- LFSR full period, zero seed ----------------
        @(negedge clk);
        start = 1'b1; mode = M_LFSR; seed = 4'd0; limit = 4'd0;
        burst_len = 8'd15; out_ready = 1'b1;
        seen = '0;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("lfsr_word%0d", i), 32'({out_valid, out_data}),
                32'({1'b1, lfsr_exp[i][3:0]}));
            seen[out_data] = 1'b1;
            @(posedge clk); #1;
        end
        chk("lfsr_all_seen", 32'(seen), 32'(16'hFFFE));
        chk("lfsr_done", 32'(outs()), 32'(pk(0, 1, 0, 1, 15)));
        @(posedge clk); #1;
        chk("lfsr_idle", 32'(outs()), 32'(pk(0, 1, 0, 0, 15)));

        // ---------------- WALK with stalls (ready 1,0,0,1,...) ----------------
        @(negedge clk);
        start = 1'b1; mode = M_WALK; seed = 4'b0001; burst_len = 8'd0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("walk_first", 32'({out_valid, out_data}), 32'({1'b1, 4'd1}));
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rdy = ((k % 3) == 0);
            out_ready = rdy;
            @(posedge clk); #1;
            if (rdy) idx++;
            chk($sformatf("walk_cyc%0d", k), 32'({out_valid, out_data}),
                32'({1'b1, walk_exp[idx % 4][3:0]}));
        end
        @(negedge clk);
        abort = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("walk_abort", 32'(outs()), 32'(pk(0, 1, 0, 0, 4)));
        @(negedge clk);
        abort = 1'b0;
        @(posedge clk); #1;
        chk("walk_no_done", 32'(outs()), 32'(pk(0, 1, 0, 0, 4)));

        // ---------------- Asynchronous reset mid-burst ----------------
        @(negedge clk);
        start = 1'b1; mode = M_UP; seed = 4'd2; limit = 4'd15; burst_len = 8'd10; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_running", 32'({out_valid, busy, out_data, word_count}),
            32'({1'b1, 1'b1, 4'd4, 8'd2}));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'(pk(0, 0, 0, 0, 0)));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post_reset_idle%0d", k), 32'(outs()), 32'(pk(0, 0, 0, 0, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
        $finish;
    end

endmodule : tb_pattern_source
`default_nettype wire
